bus_slave_port: RTL and testbench

- Bus-side responder for one memory slave on the shared serial bus; it is the target end of the master transactions issued by the master ports.
- After the arbiter routes a transaction, the block receives a mode flag, a serial address and, for writes, serial data.
- It writes or reads its local memory and, for reads, returns the data serially.
- One instance per slave; the arbiter decodes address bits [13:12], so this block sees only the 12-bit local address.

---
 rtl/bus_slave_port.sv | 161 ++++++++++++++++
 tb/tb_bus_slave_port.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_port.sv
// Serial-bus slave responder: receives mode/address/data frames and reads or writes local memory.
// Optional `SLAVE_ADDR_ERR_EN flags out-of-range addresses with an s_err pulse alongside s_ack.
module bus_slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 2048
) (
   input  logic clk,
   input  logic reset_n,
   input  logic s_valid,
   input  logic s_mode,
   input  logic s_wdata,
   output logic s_ready,
   output logic s_rdata,
   output logic s_rvalid,
   output logic s_ack,
   output logic s_err
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W) + 1;
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RFETCH, RDATA, DONE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]  addr_sr, addr_nxt;
   logic [DATA_WIDTH-1:0]  data_sr, data_nxt;
   logic                   mode, mode_nxt;
   logic                   prev_valid;
   logic                   in_range;
   logic                   mem_we;
   logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

   assign in_range = 32'(addr_sr) < 32'(MEM_DEPTH);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_sr    <= '0;
         data_sr    <= '0;
         mode       <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         addr_sr    <= addr_nxt;
         data_sr    <= data_nxt;
         mode       <= mode_nxt;
         prev_valid <= s_valid;
      end
   end

   // NOTE: memory has no reset so it maps onto RAM; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_sr[IDX_W-1:0]] <= data_sr;
   end

   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = addr_sr;
      data_nxt  = data_sr;
      mode_nxt  = mode;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            // A frame starts only on a fresh rise of s_valid.
            if (s_valid && !prev_valid) begin
               mode_nxt  = s_mode;
               addr_nxt  = {{(ADDR_WIDTH-1){1'b0}}, s_wdata};
               cnt_nxt   = CNT_W'(1);
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (!s_valid) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               addr_nxt  = '0;
               data_nxt  = '0;
            end else begin
               addr_nxt = {addr_sr[ADDR_WIDTH-2:0], s_wdata};
               if (cnt == ADDR_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = mode ? RFETCH : WDATA;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         WDATA: begin
            if (!s_valid) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               addr_nxt  = '0;
               data_nxt  = '0;
            end else begin
               data_nxt = {data_sr[DATA_WIDTH-2:0], s_wdata};
               if (cnt == DATA_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = WRITE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         WRITE: begin
            mem_we    = in_range;
            state_nxt = DONE;
         end
         RFETCH: begin
            if (!s_valid) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               addr_nxt  = '0;
               data_nxt  = '0;
            end else begin
               data_nxt  = in_range ? mem[addr_sr[IDX_W-1:0]] : '0;
               cnt_nxt   = '0;
               state_nxt = RDATA;
            end
         end
         RDATA: begin
            if (!s_valid) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               addr_nxt  = '0;
               data_nxt  = '0;
            end else begin
               data_nxt = {data_sr[DATA_WIDTH-2:0], 1'b0};
               if (cnt == DATA_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign s_ready  = (state == IDLE);
   assign s_rvalid = (state == RDATA);
   assign s_rdata  = (state == RDATA) & data_sr[DATA_WIDTH-1];
   assign s_ack    = (state == DONE);

`ifdef SLAVE_ADDR_ERR_EN
   assign s_err = (state == DONE) & ~in_range;
`else
   assign s_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed self-checking bench for bus_slave_port: write/read frames, back-to-back, abort,
// out-of-range addresses and reset in the middle of a read.
`timescale 1ns/1ps
module tb_bus_slave_port;

   localparam int AW = 12;
   localparam int DW = 8;
`ifdef SLAVE_ADDR_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic s_valid = 1'b0;
   logic s_mode = 1'b0;
   logic s_wdata = 1'b0;
   logic s_ready, s_rdata, s_rvalid, s_ack, s_err;

   int total = 0;
   int bad = 0;

   logic          rdy;
   logic [2:0]    ack3, err3;
   logic [9:0]    rv10, ack10, err10;
   logic [DW-1:0] word;

   bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(2048)) dut (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_mode(s_mode), .s_wdata(s_wdata),
      .s_ready(s_ready), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_ack(s_ack), .s_err(s_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic drive_addr(input logic mode, input logic [AW-1:0] addr);
      for (int i = AW-1; i >= 0; i--) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_mode  = mode;
         s_wdata = addr[i];
      end
   endtask

   task automatic drive_data(input logic [DW-1:0] data, input int nbits);
      for (int i = DW-1; i >= DW-nbits; i--) begin
         @(negedge clk);
         s_wdata = data[i];
      end
   endtask

   // Captures the three cycles after the last data bit: WRITE, DONE, IDLE.
   task automatic write_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit hold,
                              output logic ready_mid, output logic [2:0] ack_m, output logic [2:0] err_m);
      drive_addr(1'b0, addr);
      drive_data(data, DW);
      ready_mid = s_ready;
      ack_m = '0;
      err_m = '0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         ack_m[j] = s_ack;
         err_m[j] = s_err;
         if (!hold) s_valid = 1'b0;
      end
   endtask

   // Captures ten cycles after the last address bit: RFETCH, 8x RDATA, DONE.
   task automatic read_frame(input logic [AW-1:0] addr, output logic [DW-1:0] w,
                             output logic [9:0] rv_m, output logic [9:0] ack_m,
                             output logic [9:0] err_m, output logic ready_after);
      drive_addr(1'b1, addr);
      w = '0;
      rv_m = '0;
      ack_m = '0;
      err_m = '0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         rv_m[j]  = s_rvalid;
         ack_m[j] = s_ack;
         err_m[j] = s_err;
         if (s_rvalid) w = {w[DW-2:0], s_rdata};
      end
      s_valid = 1'b0;
      @(negedge clk);
      ready_after = s_ready;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      total++; if (s_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
      total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", s_rvalid); end
      total++; if (s_rdata !== 1'b0)  begin bad++; $display("FAIL reset_rdata: got %b want 0", s_rdata); end
      total++; if (s_ack !== 1'b0)    begin bad++; $display("FAIL reset_ack: got %b want 0", s_ack); end
      total++; if (s_err !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", s_err); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      write_frame(12'd1001, 8'd212, 1'b0, rdy, ack3, err3);
      total++; if (rdy !== 1'b0)      begin bad++; $display("FAIL write_ready_mid: got %b want 0", rdy); end
      total++; if (ack3 !== 3'b010)   begin bad++; $display("FAIL write_ack: got %b want 010", ack3); end
      total++; if (err3 !== 3'b000)   begin bad++; $display("FAIL write_err: got %b want 000", err3); end
      total++; if (s_ready !== 1'b1)  begin bad++; $display("FAIL write_ready_after: got %b want 1", s_ready); end
   endtask

   task automatic test_read();
      read_frame(12'd1001, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'b11010100)      begin bad++; $display("FAIL read_data: got %b want 11010100", word); end
      total++; if (rv10 !== 10'b0111111110)   begin bad++; $display("FAIL read_rvalid: got %b want 0111111110", rv10); end
      total++; if (ack10 !== 10'b1000000000)  begin bad++; $display("FAIL read_ack: got %b want 1000000000", ack10); end
      total++; if (err10 !== 10'b0)           begin bad++; $display("FAIL read_err: got %b want 0", err10); end
      total++; if (rdy !== 1'b1)              begin bad++; $display("FAIL read_ready_after: got %b want 1", rdy); end
   endtask

   task automatic test_back_to_back();
      write_frame(12'd916, 8'd78, 1'b1, rdy, ack3, err3);
      total++; if (ack3 !== 3'b010)  begin bad++; $display("FAIL b2b_write_ack: got %b want 010", ack3); end
      @(negedge clk);
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_held_valid: got ready %b want 1", s_ready); end
      s_valid = 1'b0;
      read_frame(12'd916, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'b01001110)     begin bad++; $display("FAIL b2b_read_data: got %b want 01001110", word); end
      total++; if (ack10 !== 10'b1000000000) begin bad++; $display("FAIL b2b_read_ack: got %b want 1000000000", ack10); end
   endtask

   task automatic test_abort();
      logic [3:0] ack4;
      logic       rdy_now;
      drive_addr(1'b0, 12'd916);
      drive_data(8'hFF, 4);
      @(negedge clk);
      s_valid = 1'b0;
      ack4 = '0;
      rdy_now = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         ack4[j] = s_ack;
         if (j == 0) rdy_now = s_ready;
      end
      total++; if (rdy_now !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", rdy_now); end
      total++; if (ack4 !== 4'b0000) begin bad++; $display("FAIL abort_ack: got %b want 0000", ack4); end
      read_frame(12'd916, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'd78)   begin bad++; $display("FAIL abort_mem_kept: got %0d want 78", word); end
   endtask

   task automatic test_out_of_range();
      logic [2:0] err3_exp;
      logic [9:0] err10_exp;
      err3_exp  = ERR_EN ? 3'b010 : 3'b000;
      err10_exp = ERR_EN ? 10'b1000000000 : 10'b0;
      write_frame(12'd952, 8'h33, 1'b0, rdy, ack3, err3);
      total++; if (err3 !== 3'b000)   begin bad++; $display("FAIL oor_inrange_err: got %b want 000", err3); end
      write_frame(12'd3000, 8'hAA, 1'b0, rdy, ack3, err3);
      total++; if (ack3 !== 3'b010)   begin bad++; $display("FAIL oor_write_ack: got %b want 010", ack3); end
      total++; if (err3 !== err3_exp) begin bad++; $display("FAIL oor_write_err: got %b want %b", err3, err3_exp); end
      read_frame(12'd3000, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'h00)             begin bad++; $display("FAIL oor_read_data: got %h want 00", word); end
      total++; if (rv10 !== 10'b0111111110)    begin bad++; $display("FAIL oor_read_rvalid: got %b want 0111111110", rv10); end
      total++; if (ack10 !== 10'b1000000000)   begin bad++; $display("FAIL oor_read_ack: got %b want 1000000000", ack10); end
      total++; if (err10 !== err10_exp)        begin bad++; $display("FAIL oor_read_err: got %b want %b", err10, err10_exp); end
      read_frame(12'd952, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'h33)             begin bad++; $display("FAIL oor_write_dropped: got %h want 33", word); end
   endtask

   task automatic test_reset_mid_read();
      drive_addr(1'b1, 12'd1001);
      for (int j = 0; j < 4; j++) @(negedge clk);
      total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL rst_pre_rvalid: got %b want 1", s_rvalid); end
      reset_n = 1'b0;
      s_valid = 1'b0;
      #1;
      total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid: got %b want 0", s_rvalid); end
      total++; if (s_ready !== 1'b1)  begin bad++; $display("FAIL rst_mid_ready: got %b want 1", s_ready); end
      total++; if (s_rdata !== 1'b0)  begin bad++; $display("FAIL rst_mid_rdata: got %b want 0", s_rdata); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      read_frame(12'd1001, word, rv10, ack10, err10, rdy);
      total++; if (word !== 8'd212)          begin bad++; $display("FAIL rst_next_data: got %0d want 212", word); end
      total++; if (ack10 !== 10'b1000000000) begin bad++; $display("FAIL rst_next_ack: got %b want 1000000000", ack10); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_abort();
      test_out_of_range();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
